// File: rtl/mips_pkg.sv
// Shared widths and constants for the MIPS pipeline.
// Register 0 is the architectural zero register.
package mips_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/write_back_mux.sv
// Write-back source select: load data or ALU result.
// Purely combinational, also feeds the forwarding path.
module write_back_mux
  import mips_pkg::*;
#(
  parameter int WIDTH = mips_pkg::DATA_WIDTH
) (
  input  logic             memory_to_register,
  input  logic [WIDTH-1:0] memory_data,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] data
);

  assign data = memory_to_register ? memory_data : alu_result;

endmodule

// File: rtl/write_back_register_file.sv
// MIPS write-back stage and 32-entry register file with
// write-first read bypass and a committed-write counter.
module write_back_register_file
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = mips_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] memory_data_in,
  input  logic [DATA_WIDTH-1:0] alu_result_in,
  input  logic [ADDR_WIDTH-1:0] register_destination_in,
  input  logic                  memory_to_register_in,
  input  logic                  reg_write_in,
  input  logic [ADDR_WIDTH-1:0] read_register_1,
  input  logic [ADDR_WIDTH-1:0] read_register_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  output logic [DATA_WIDTH-1:0] write_back_data,
  output logic [31:0]           write_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  commit;

  write_back_mux #(
    .WIDTH(DATA_WIDTH)
  ) u_mux (
    .memory_to_register(memory_to_register_in),
    .memory_data       (memory_data_in),
    .alu_result        (alu_result_in),
    .data              (write_back_data)
  );

  assign commit = reg_write_in &&
    (register_destination_in != ZERO_REG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (commit) begin
      regs[register_destination_in] <= write_back_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      write_count <= '0;
    else if (commit)
      write_count <= write_count + 32'd1;
  end

  // Bypass stays live in reset; zero register wins over bypass.
  always_comb begin
    read_data_1 = regs[read_register_1];
    if (commit && read_register_1 == register_destination_in)
      read_data_1 = write_back_data;
    if (read_register_1 == ZERO_REG)
      read_data_1 = '0;
  end

  always_comb begin
    read_data_2 = regs[read_register_2];
    if (commit && read_register_2 == register_destination_in)
      read_data_2 = write_back_data;
    if (read_register_2 == ZERO_REG)
      read_data_2 = '0;
  end

endmodule

// File: tb/tb_write_back_register_file.sv
// Bench for write_back_register_file: directed cases
// plus random traffic against an array-based model.
module tb_write_back_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] memory_data_in;
  logic [31:0] alu_result_in;
  logic [4:0]  register_destination_in;
  logic        memory_to_register_in;
  logic        reg_write_in;
  logic [4:0]  read_register_1;
  logic [4:0]  read_register_2;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] write_back_data;
  logic [31:0] write_count;

  always #10 clk = ~clk;

  write_back_register_file dut (
    .clk                    (clk),
    .rst                    (rst),
    .memory_data_in         (memory_data_in),
    .alu_result_in          (alu_result_in),
    .register_destination_in(register_destination_in),
    .memory_to_register_in  (memory_to_register_in),
    .reg_write_in           (reg_write_in),
    .read_register_1        (read_register_1),
    .read_register_2        (read_register_2),
    .read_data_1            (read_data_1),
    .read_data_2            (read_data_2),
    .write_back_data        (write_back_data),
    .write_count            (write_count)
  );

  int          checks = 0;
  int          failures = 0;
  logic        cmp_en = 1'b0;
  logic [31:0] model [32];
  logic [31:0] model_count;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_wb();
    return memory_to_register_in ? memory_data_in : alu_result_in;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (reg_write_in && register_destination_in != 5'd0 &&
        a == register_destination_in)
      return exp_wb();
    return model[a];
  endfunction

  // Architectural state: what a commit does, from the rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model_count = 32'd0;
    end else if (reg_write_in && register_destination_in != 5'd0) begin
      model[register_destination_in] = exp_wb();
      model_count = model_count + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_wb", write_back_data, exp_wb());
      chk("cyc_rd1", read_data_1, exp_read(read_register_1));
      chk("cyc_rd2", read_data_2, exp_read(read_register_2));
      chk("cyc_count", write_count, model_count);
    end
  end

  task automatic drive(input logic rw, input logic m2r,
                       input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] dest, input logic [4:0] r1,
                       input logic [4:0] r2);
    @(posedge clk);
    #1;
    reg_write_in            = rw;
    memory_to_register_in   = m2r;
    memory_data_in          = mem;
    alu_result_in           = alu;
    register_destination_in = dest;
    read_register_1         = r1;
    read_register_2         = r2;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model_count             = 32'd0;
    reg_write_in            = 1'b0;
    memory_to_register_in   = 1'b0;
    memory_data_in          = 32'd0;
    alu_result_in           = 32'd0;
    register_destination_in = 5'd0;
    read_register_1         = 5'd0;
    read_register_2         = 5'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 32; i++) begin
      read_register_1 = 5'(i);
      read_register_2 = 5'(31 - i);
      #1;
      chk("reset_rd1", read_data_1, 32'd0);
      chk("reset_rd2", read_data_2, 32'd0);
    end
    chk("reset_count", write_count, 32'd0);

    @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;

    drive(1, 0, 32'h0, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd0);
    #2 chk("bypass_r5", read_data_1, 32'hDEAD_BEEF);
    drive(0, 0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd0);
    #2 chk("stored_r5", read_data_1, 32'hDEAD_BEEF);
    chk("count_1", write_count, 32'd1);

    drive(1, 1, 32'h1234_5678, 32'hFFFF_FFFF, 5'd7, 5'd7, 5'd5);
    #2 chk("mem_sel_wb", write_back_data, 32'h1234_5678);
    chk("mem_sel_bypass", read_data_1, 32'h1234_5678);
    drive(0, 0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd5);
    #2 chk("stored_r7", read_data_1, 32'h1234_5678);
    chk("keep_r5", read_data_2, 32'hDEAD_BEEF);
    chk("count_2", write_count, 32'd2);

    drive(1, 0, 32'h0, 32'hAAAA_AAAA, 5'd0, 5'd0, 5'd0);
    #2 chk("r0_same", read_data_1, 32'd0);
    drive(0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #2 chk("r0_next", read_data_1, 32'd0);
    chk("r0_count", write_count, 32'd2);

    drive(0, 0, 32'h0, 32'h5555_5555, 5'd9, 5'd9, 5'd9);
    #2 chk("nowr_rd1", read_data_1, 32'd0);
    chk("nowr_rd2", read_data_2, 32'd0);
    drive(0, 0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);
    #2 chk("nowr_r9", read_data_1, 32'd0);
    chk("nowr_count", write_count, 32'd2);

    drive(1, 0, 32'h0, 32'd1, 5'd1, 5'd0, 5'd0);
    drive(1, 0, 32'h0, 32'd2, 5'd2, 5'd0, 5'd0);
    drive(1, 0, 32'h0, 32'd3, 5'd3, 5'd0, 5'd0);
    drive(1, 0, 32'h0, 32'h44, 5'd4, 5'd1, 5'd2);
    #2 chk("pre_rst_r1", read_data_1, 32'd1);
    chk("pre_rst_count", write_count, 32'd5);
    #1 rst = 1'b1;
    #1 chk("rst_r1", read_data_1, 32'd0);
    chk("rst_r2", read_data_2, 32'd0);
    chk("rst_count", write_count, 32'd0);
    read_register_1 = 5'd3;
    read_register_2 = 5'd4;
    #1 chk("rst_r3", read_data_1, 32'd0);
    chk("rst_bypass_r4", read_data_2, 32'h44);
    reg_write_in = 1'b0;
    #1 chk("rst_r4", read_data_2, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd4);
    #2 chk("post_rst_r4", read_data_1, 32'd0);
    chk("post_rst_count", write_count, 32'd0);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] d;
      d = 5'($urandom_range(0, 31));
      drive($urandom_range(0, 3) != 0, 1'($urandom),
            $urandom, $urandom, d,
            ($urandom_range(0, 1) != 0) ? d : 5'($urandom),
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom));
    end

    @(posedge clk);
    #1 cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
